div_sched: RTL

Two-port scheduler that shares the single iterative `div` unit between two requesters, such as two issue lanes or an issue lane plus a microcode sequencer. It arbitrates round-robin and forwards one operation at a time to the divider. A zero divisor is short-circuited without occupying the divider. The result is held with tag and port ID under valid/ready backpressure, and a flush cancels in-flight work. It sits between the issue/execute stage and `div`, and is the only block that drives `div`'s request port.

---
 rtl/div_sched_pkg.sv | 32 +++
 rtl/arb_rr2.sv | 31 +++
 rtl/div_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared definitions for the divider scheduler: div op bit positions, FSM state encoding,
// and the zero-divisor result rule used by the fast path.
package div_sched_pkg;

    localparam int DIV_OP_UNSIGNED = 0;
    localparam int DIV_OP_REM      = 1;
    localparam int DIV_OP_WORD     = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [63:0] operand1;
        logic [63:0] operand2;
        logic [2:0]  op;
    } div_cmd_t;

    // Word ops only look at the low half of the divisor.
    function automatic logic divisor_is_zero(input div_cmd_t cmd);
        if (cmd.op[DIV_OP_WORD]) return cmd.operand2[31:0] == 32'd0;
        return cmd.operand2 == 64'd0;
    endfunction

    function automatic logic [63:0] zero_div_result(input div_cmd_t cmd);
        if (!cmd.op[DIV_OP_REM]) return '1;
        if (cmd.op[DIV_OP_WORD]) return {{32{cmd.operand1[31]}}, cmd.operand1[31:0]};
        return cmd.operand1;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin arbiter: combinational grant, pointer moves to the other
// requester only after a contested grant is consumed (advance).
module arb_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance && (req == 2'b11)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one iterative divider between two requesters; one op in flight, zero divisors answered
// locally one cycle after acceptance, results held under resp_valid/resp_ready, flush cancels work.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_operand1,
    input  logic [63:0]      req0_operand2,
    input  logic [2:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_operand1,
    input  logic [63:0]      req1_operand2,
    input  logic [2:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic             div_req_valid,
    input  logic             div_req_ready,
    output logic [63:0]      div_operand1,
    output logic [63:0]      div_operand2,
    output logic [2:0]       div_op,
    input  logic             div_resp_valid,
    input  logic [63:0]      div_resp_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_port,
    output logic [TAG_W-1:0] resp_tag,
    output logic [63:0]      resp_result
);

    logic [1:0]       state;
    logic [1:0]       grant;
    logic             sel;
    logic             issue_ok;
    logic             accept;
    logic             zero_div;
    div_cmd_t         cmd0;
    div_cmd_t         cmd1;
    div_cmd_t         cmd;
    logic             port_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      result_q;

    arb_rr2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    assign cmd0     = {req0_operand1, req0_operand2, req0_op};
    assign cmd1     = {req1_operand1, req1_operand2, req1_op};
    assign sel      = grant[1];
    assign cmd      = sel ? cmd1 : cmd0;
    assign zero_div = divisor_is_zero(cmd);

    // Acceptance also waits on div_req_ready for zero divisors so both paths share one handshake rule.
    assign issue_ok      = (state == ST_IDLE) && !flush && !rst;
    assign req0_ready    = issue_ok && grant[0] && div_req_ready;
    assign req1_ready    = issue_ok && grant[1] && div_req_ready;
    assign accept        = req0_ready || req1_ready;
    assign div_req_valid = issue_ok && (grant != 2'b00) && !zero_div;
    assign div_operand1  = cmd.operand1;
    assign div_operand2  = cmd.operand2;
    assign div_op        = cmd.op;

    // A flushed result never presents a valid, so it can never complete a handshake.
    assign resp_valid  = (state == ST_HOLD) && !flush;
    assign resp_port   = port_q;
    assign resp_tag    = tag_q;
    assign resp_result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) state <= zero_div ? ST_HOLD : ST_BUSY;
                end
                ST_BUSY: begin
                    // A flush coinciding with the response has nothing left to drain.
                    if (div_resp_valid)  state <= flush ? ST_IDLE : ST_HOLD;
                    else if (flush)      state <= ST_DRAIN;
                end
                ST_HOLD: begin
                    if (flush || resp_ready) state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (div_resp_valid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            port_q   <= sel;
            tag_q    <= sel ? req1_tag : req0_tag;
            result_q <= zero_div_result(cmd);
        end else if ((state == ST_BUSY) && div_resp_valid) begin
            result_q <= div_resp_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && div_resp_valid) begin
            assert ((state == ST_BUSY) || (state == ST_DRAIN))
                else $error("div_sched: divider response with no operation outstanding");
        end
    end

endmodule
